// File: rtl/segre_store_buffer.sv
// segre_store_buffer: post-commit store FIFO that drains to the data cache in idle cycles and forwards to MEM loads
module segre_store_buffer #(
    parameter int NUM_ENTRIES = 4,
    parameter int ADDR_W      = 32,
    parameter int DATA_W      = 32
) (
    input  logic                clk_i,
    input  logic                rsn_i,
    input  logic                store_valid_i,
    input  logic [ADDR_W-1:0]   store_addr_i,
    input  logic [DATA_W-1:0]   store_data_i,
    input  logic [DATA_W/8-1:0] store_be_i,
    input  logic                load_valid_i,
    input  logic [ADDR_W-1:0]   load_addr_i,
    input  logic [DATA_W/8-1:0] load_be_i,
    output logic                fwd_hit_o,
    output logic [DATA_W-1:0]   fwd_data_o,
    input  logic                dc_idle_i,
    output logic                dc_wr_o,
    output logic [ADDR_W-1:0]   dc_addr_o,
    output logic [DATA_W-1:0]   dc_data_o,
    output logic [DATA_W/8-1:0] dc_be_o,
    input  logic                dc_ack_i,
    input  logic                flush_i,
    output logic                flush_done_o,
    output logic                draining_o,
    output logic                full_o,
    output logic                empty_o
);
    localparam int BE_W = DATA_W / 8;
    localparam int PW   = $clog2(NUM_ENTRIES);
    localparam int CW   = PW + 1;
    localparam int AW   = ADDR_W - 2;

    typedef enum logic [1:0] {IDLE, WRITE, FLUSH} state_t;

    state_t                 state_q, state_d;
    logic [AW-1:0]          addr_q [NUM_ENTRIES];
    logic [DATA_W-1:0]      data_q [NUM_ENTRIES];
    logic [BE_W-1:0]        be_q   [NUM_ENTRIES];
    logic [NUM_ENTRIES-1:0] valid_q;
    logic [PW-1:0]          head_q, head_d, tail_q, tail_d;
    logic [CW-1:0]          count_q, count_d;
    logic                   enq, deq, match, covered, partial;
    logic [PW-1:0]          idx;
    logic [DATA_W-1:0]      match_data;
    logic [BE_W-1:0]        match_be;
    logic                   unused_addr_bits;

    assign unused_addr_bits = ^{store_addr_i[1:0], load_addr_i[1:0]};

    assign full_o       = count_q == CW'(NUM_ENTRIES);
    assign empty_o      = count_q == '0;
    assign dc_wr_o      = state_q == WRITE || (state_q == FLUSH && !empty_o);
    assign dc_addr_o    = {addr_q[head_q], 2'b00};
    assign dc_data_o    = data_q[head_q];
    assign dc_be_o      = be_q[head_q];
    assign deq          = dc_wr_o && dc_ack_i;
    assign enq          = store_valid_i && state_q != FLUSH && (!full_o || deq);
    assign flush_done_o = state_q == FLUSH && empty_o;

    // Drain FSM next state; flush requests take priority over normal draining
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    state_d = flush_i ? FLUSH : (!empty_o && dc_idle_i) ? WRITE : IDLE;
            WRITE:   state_d = flush_i ? FLUSH : deq ? IDLE : WRITE;
            FLUSH:   state_d = empty_o ? IDLE : FLUSH;
            default: state_d = IDLE;
        endcase
    end

    // Pointer and occupancy update
    always_comb begin
        head_d  = head_q + PW'(deq);
        tail_d  = tail_q + PW'(enq);
        count_d = count_q + CW'(enq) - CW'(deq);
    end

    // Forwarding search from oldest to youngest so the youngest match is kept
    always_comb begin
        match      = 1'b0;
        match_data = '0;
        match_be   = '0;
        idx        = '0;
        for (int i = 0; i < NUM_ENTRIES; i++) begin
            idx = head_q + PW'(i);
            if (valid_q[idx] && addr_q[idx] == load_addr_i[ADDR_W-1:2]) begin
                match      = 1'b1;
                match_data = data_q[idx];
                match_be   = be_q[idx];
            end
        end
        covered    = (match_be & load_be_i) == load_be_i;
        fwd_hit_o  = load_valid_i && match && covered;
        partial    = load_valid_i && match && !covered;
        fwd_data_o = fwd_hit_o ? match_data : '0;
        draining_o = (store_valid_i && full_o && !deq) || partial || state_q == FLUSH;
    end

    // Control state registers
    always_ff @(posedge clk_i or negedge rsn_i) begin
        if (!rsn_i) begin
            state_q <= IDLE;
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            state_q <= state_d;
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
        end
    end

    // Entry storage; an enqueue into the slot being dequeued (full case) keeps it valid
    always_ff @(posedge clk_i or negedge rsn_i) begin
        if (!rsn_i) begin
            valid_q <= '0;
            for (int i = 0; i < NUM_ENTRIES; i++) begin
                addr_q[i] <= '0;
                data_q[i] <= '0;
                be_q[i]   <= '0;
            end
        end else begin
            if (deq) valid_q[head_q] <= 1'b0;
            if (enq) begin
                valid_q[tail_q] <= 1'b1;
                addr_q[tail_q]  <= store_addr_i[ADDR_W-1:2];
                data_q[tail_q]  <= store_data_i;
                be_q[tail_q]    <= store_be_i;
            end
        end
    end
endmodule

// File: tb/tb_segre_store_buffer.sv
// tb_segre_store_buffer: scenario tasks with a write scoreboard for segre_store_buffer
module tb_segre_store_buffer;
    logic        clk = 1'b0;
    logic        rsn;
    logic        store_valid, load_valid, dc_idle, dc_ack, flush;
    logic [31:0] store_addr, store_data, load_addr;
    logic [3:0]  store_be, load_be;
    logic        fwd_hit, dc_wr_o, flush_done_o, draining_o, full_o, empty_o;
    logic [31:0] fwd_data, dc_addr_o, dc_data_o;
    logic [3:0]  dc_be_o;
    int          checks = 0;
    int          failures = 0;

    typedef struct {
        logic [31:0] a;
        logic [31:0] d;
        logic [3:0]  be;
    } wr_t;
    wr_t sb[$];
    wr_t exp_wr;

    always #5 clk = ~clk;

    segre_store_buffer dut (
        .clk_i(clk), .rsn_i(rsn),
        .store_valid_i(store_valid), .store_addr_i(store_addr), .store_data_i(store_data), .store_be_i(store_be),
        .load_valid_i(load_valid), .load_addr_i(load_addr), .load_be_i(load_be),
        .fwd_hit_o(fwd_hit), .fwd_data_o(fwd_data),
        .dc_idle_i(dc_idle), .dc_wr_o(dc_wr_o), .dc_addr_o(dc_addr_o), .dc_data_o(dc_data_o), .dc_be_o(dc_be_o),
        .dc_ack_i(dc_ack), .flush_i(flush), .flush_done_o(flush_done_o),
        .draining_o(draining_o), .full_o(full_o), .empty_o(empty_o)
    );

    // Every accepted cache write must match the oldest expected store
    always begin
        @(negedge clk);
        #3;
        if (rsn && dc_wr_o && dc_ack) begin
            checks++;
            if (sb.size() == 0) begin
                failures++;
                $display("FAIL dc_write_unexpected got addr=%h data=%h be=%h required no write", dc_addr_o, dc_data_o, dc_be_o);
            end else begin
                exp_wr = sb.pop_front();
                if ({dc_addr_o, dc_data_o, dc_be_o} !== {exp_wr.a, exp_wr.d, exp_wr.be}) begin
                    failures++;
                    $display("FAIL dc_write got addr=%h data=%h be=%h required addr=%h data=%h be=%h",
                             dc_addr_o, dc_data_o, dc_be_o, exp_wr.a, exp_wr.d, exp_wr.be);
                end
            end
        end
    end

    task automatic put(input logic [31:0] a, input logic [31:0] d, input logic [3:0] be);
        store_valid = 1'b1;
        store_addr  = a;
        store_data  = d;
        store_be    = be;
        sb.push_back('{a, d, be});
        @(negedge clk);
        store_valid = 1'b0;
    endtask

    task automatic drain();
        dc_idle = 1'b1;
        dc_ack  = 1'b1;
        for (int i = 0; i < 60 && !(empty_o && sb.size() == 0); i++) @(negedge clk);
        dc_idle = 1'b0;
        dc_ack  = 1'b0;
    endtask

    task automatic test_reset();
        rsn = 1'b0;
        store_valid = 0; load_valid = 0; dc_idle = 0; dc_ack = 0; flush = 0;
        store_addr = 0; store_data = 0; store_be = 0; load_addr = 0; load_be = 0;
        repeat (2) @(negedge clk);
        #2;
        checks++;
        if (empty_o !== 1'b1) begin failures++; $display("FAIL reset_empty got %b required 1", empty_o); end
        checks++;
        if ({full_o, dc_wr_o, draining_o, flush_done_o, fwd_hit} !== 5'b0) begin
            failures++;
            $display("FAIL reset_flags got full=%b wr=%b drain=%b done=%b hit=%b required all 0", full_o, dc_wr_o, draining_o, flush_done_o, fwd_hit);
        end
        checks++;
        if (fwd_data !== 32'h0) begin failures++; $display("FAIL reset_fwd_data got %h required 0", fwd_data); end
        @(negedge clk);
        rsn = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_fifo_order();
        put(32'h100, 32'hAAAA0001, 4'hF);
        put(32'h104, 32'hBBBB0002, 4'hF);
        put(32'h108, 32'hCCCC0003, 4'hF);
        #2;
        checks++;
        if ({dc_wr_o, empty_o, full_o} !== 3'b000) begin
            failures++;
            $display("FAIL fifo_hold got wr=%b empty=%b full=%b required 0 0 0", dc_wr_o, empty_o, full_o);
        end
        @(negedge clk);
        drain();
        #2;
        checks++;
        if (empty_o !== 1'b1 || sb.size() != 0) begin
            failures++;
            $display("FAIL fifo_drain got empty=%b pending=%0d required empty=1 pending=0", empty_o, sb.size());
        end
    endtask

    task automatic test_full();
        int n;
        @(negedge clk);
        put(32'h400, 32'h40404040, 4'hF);
        put(32'h404, 32'h41414141, 4'hF);
        put(32'h408, 32'h42424242, 4'hF);
        put(32'h40C, 32'h43434343, 4'hF);
        store_valid = 1'b1; store_addr = 32'h410; store_data = 32'h44444444; store_be = 4'hF;
        #2;
        checks++;
        if ({full_o, draining_o} !== 2'b11) begin
            failures++;
            $display("FAIL full_stall got full=%b draining=%b required 1 1", full_o, draining_o);
        end
        @(negedge clk);
        dc_idle = 1'b1;
        dc_ack  = 1'b1;
        #2;
        n = 0;
        while (draining_o && n < 10) begin
            @(negedge clk);
            #2;
            n++;
        end
        checks++;
        if ({draining_o, dc_wr_o} !== 2'b01) begin
            failures++;
            $display("FAIL full_ack_cycle got draining=%b wr=%b required 0 1", draining_o, dc_wr_o);
        end
        sb.push_back('{32'h410, 32'h44444444, 4'hF});
        @(negedge clk);
        store_valid = 1'b0;
        dc_idle = 1'b0;
        dc_ack  = 1'b0;
        #2;
        checks++;
        if (full_o !== 1'b1) begin failures++; $display("FAIL full_after_swap got %b required 1", full_o); end
        drain();
        #2;
        checks++;
        if (empty_o !== 1'b1 || sb.size() != 0) begin
            failures++;
            $display("FAIL full_drain got empty=%b pending=%0d required empty=1 pending=0", empty_o, sb.size());
        end
    endtask

    task automatic test_forward();
        @(negedge clk);
        put(32'h200, 32'h11111111, 4'hF);
        put(32'h200, 32'h22222222, 4'hF);
        load_valid = 1'b1; load_addr = 32'h200; load_be = 4'hF;
        #2;
        checks++;
        if ({fwd_hit, fwd_data, draining_o} !== {1'b1, 32'h22222222, 1'b0}) begin
            failures++;
            $display("FAIL fwd_youngest got hit=%b data=%h drain=%b required 1 22222222 0", fwd_hit, fwd_data, draining_o);
        end
        load_be = 4'h3;
        #1;
        checks++;
        if ({fwd_hit, fwd_data} !== {1'b1, 32'h22222222}) begin
            failures++;
            $display("FAIL fwd_subset got hit=%b data=%h required 1 22222222", fwd_hit, fwd_data);
        end
        load_addr = 32'h204; load_be = 4'hF;
        #1;
        checks++;
        if ({fwd_hit, fwd_data, draining_o} !== {1'b0, 32'h0, 1'b0}) begin
            failures++;
            $display("FAIL fwd_miss got hit=%b data=%h drain=%b required 0 0 0", fwd_hit, fwd_data, draining_o);
        end
        @(negedge clk);
        load_addr = 32'h200;
        store_valid = 1'b1; store_addr = 32'h200; store_data = 32'h33333333; store_be = 4'hF;
        sb.push_back('{32'h200, 32'h33333333, 4'hF});
        #2;
        checks++;
        if ({fwd_hit, fwd_data} !== {1'b1, 32'h22222222}) begin
            failures++;
            $display("FAIL fwd_same_cycle_store got hit=%b data=%h required 1 22222222", fwd_hit, fwd_data);
        end
        @(negedge clk);
        store_valid = 1'b0;
        #2;
        checks++;
        if (fwd_data !== 32'h33333333) begin failures++; $display("FAIL fwd_after_store got %h required 33333333", fwd_data); end
        load_valid = 1'b0;
        #1;
        checks++;
        if ({fwd_hit, fwd_data} !== {1'b0, 32'h0}) begin
            failures++;
            $display("FAIL fwd_no_load got hit=%b data=%h required 0 0", fwd_hit, fwd_data);
        end
        @(negedge clk);
        drain();
    endtask

    task automatic test_partial();
        int n;
        @(negedge clk);
        put(32'h300, 32'h12345678, 4'hF);
        put(32'h300, 32'h000000EE, 4'h1);
        load_valid = 1'b1; load_addr = 32'h300; load_be = 4'hF;
        #2;
        checks++;
        if ({fwd_hit, draining_o} !== 2'b01) begin
            failures++;
            $display("FAIL partial_conflict got hit=%b draining=%b required 0 1", fwd_hit, draining_o);
        end
        load_be = 4'h1;
        #1;
        checks++;
        if ({fwd_hit, fwd_data, draining_o} !== {1'b1, 32'h000000EE, 1'b0}) begin
            failures++;
            $display("FAIL partial_byte_hit got hit=%b data=%h drain=%b required 1 000000ee 0", fwd_hit, fwd_data, draining_o);
        end
        load_be = 4'hF;
        @(negedge clk);
        dc_idle = 1'b1;
        dc_ack  = 1'b1;
        #2;
        n = 0;
        while (draining_o && n < 20) begin
            @(negedge clk);
            #2;
            n++;
        end
        checks++;
        if ({draining_o, empty_o, fwd_hit} !== 3'b010 || n < 3) begin
            failures++;
            $display("FAIL partial_release got draining=%b empty=%b hit=%b cycles=%0d required 0 1 0 cycles>=3", draining_o, empty_o, fwd_hit, n);
        end
        load_valid = 1'b0;
        dc_idle = 1'b0;
        dc_ack  = 1'b0;
    endtask

    task automatic test_flush();
        int last, done;
        @(negedge clk);
        put(32'h500, 32'h50505050, 4'hF);
        put(32'h504, 32'h51515151, 4'hC);
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        #2;
        checks++;
        if ({dc_wr_o, draining_o, flush_done_o} !== 3'b110) begin
            failures++;
            $display("FAIL flush_start got wr=%b draining=%b done=%b required 1 1 0", dc_wr_o, draining_o, flush_done_o);
        end
        store_valid = 1'b1; store_addr = 32'h5F0; store_data = 32'hDEADBEEF; store_be = 4'hF;
        @(negedge clk);
        #2;
        dc_ack = 1'b1;
        last = -1;
        done = -1;
        for (int n = 0; n < 20; n++) begin
            checks++;
            if (draining_o !== 1'b1) begin failures++; $display("FAIL flush_draining cycle=%0d got %b required 1", n, draining_o); end
            if (dc_wr_o && dc_ack) last = n;
            if (flush_done_o) begin
                done = n;
                break;
            end
            @(negedge clk);
            #2;
        end
        store_valid = 1'b0;
        dc_ack = 1'b0;
        checks++;
        if (last < 0 || done != last + 1) begin
            failures++;
            $display("FAIL flush_done_timing got done_cycle=%0d last_ack_cycle=%0d required done=last+1", done, last);
        end
        @(negedge clk);
        #2;
        checks++;
        if ({flush_done_o, empty_o, draining_o, dc_wr_o} !== 4'b0100) begin
            failures++;
            $display("FAIL flush_end got done=%b empty=%b draining=%b wr=%b required 0 1 0 0", flush_done_o, empty_o, draining_o, dc_wr_o);
        end
        @(negedge clk);
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        #2;
        checks++;
        if (flush_done_o !== 1'b1) begin failures++; $display("FAIL flush_empty_done got %b required 1", flush_done_o); end
        @(negedge clk);
        #2;
        checks++;
        if (flush_done_o !== 1'b0) begin failures++; $display("FAIL flush_empty_pulse got %b required 0", flush_done_o); end
    endtask

    task automatic test_async_reset();
        @(negedge clk);
        put(32'h600, 32'h60606060, 4'hF);
        put(32'h604, 32'h61616161, 4'hF);
        put(32'h608, 32'h62626262, 4'hF);
        dc_idle = 1'b1;
        @(negedge clk);
        #2;
        checks++;
        if (dc_wr_o !== 1'b1) begin failures++; $display("FAIL rst_pre_write got %b required 1", dc_wr_o); end
        rsn = 1'b0;
        #1;
        checks++;
        if ({empty_o, dc_wr_o, full_o} !== 3'b100) begin
            failures++;
            $display("FAIL rst_async got empty=%b wr=%b full=%b required 1 0 0", empty_o, dc_wr_o, full_o);
        end
        sb.delete();
        dc_idle = 1'b0;
        @(negedge clk);
        rsn = 1'b1;
        @(negedge clk);
        #2;
        checks++;
        if ({dc_wr_o, empty_o} !== 2'b01) begin
            failures++;
            $display("FAIL rst_idle got wr=%b empty=%b required 0 1", dc_wr_o, empty_o);
        end
        @(negedge clk);
        put(32'h700, 32'h70707070, 4'h5);
        drain();
        #2;
        checks++;
        if (empty_o !== 1'b1 || sb.size() != 0) begin
            failures++;
            $display("FAIL rst_recover got empty=%b pending=%0d required empty=1 pending=0", empty_o, sb.size());
        end
    endtask

    initial begin
        test_reset();
        test_fifo_order();
        test_full();
        test_forward();
        test_partial();
        test_flush();
        test_async_reset();
        @(negedge clk);
        checks++;
        if (sb.size() != 0) begin failures++; $display("FAIL sb_leftover got %0d required 0", sb.size()); end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
